// File: rtl/fx2_fifo_arbiter.sv
// fx2_fifo_arbiter: shares the FX2LP slave-FIFO bus between an outgoing TX byte
// stream (write endpoint) and an incoming RX byte stream (read endpoint).
// Round-robin bursts, one-cycle bus turnaround, packet byte counting and
// short-packet commit via PKTENDN.
// Optional feature: define FX2_ZLP_EN to send a zero-length packet when a flush
// arrives on a packet boundary (otherwise such a flush is dropped).
module fx2_fifo_arbiter #(
    parameter logic [1:0]  WR_EP_ADDR = 2'b10,
    parameter logic [1:0]  RD_EP_ADDR = 2'b00,
    parameter int unsigned PKT_BYTES  = 512,
    parameter int unsigned BURST_MAX  = 64
) (
    input  logic       IFCLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       FLUSH,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    inout  tri   [7:0] FD,
    output logic       SLRDN,
    output logic       SLWRN,
    output logic       SLOEN,
    output logic       PKTENDN,
    output logic [1:0] FIFOADR,
    input  logic [2:0] FLAGN
);

    localparam int unsigned PW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int unsigned BW = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_SETUP,
        S_RD,
        S_TURN,
        S_PKTEND
    } state_t;

    state_t        state;
    logic [PW-1:0] pkt_cnt;
    logic [BW-1:0] burst_cnt;
    logic          flush_pend;
    logic          last_rd;

    logic tx_req;
    logic rx_req;
    logic burst_full;
    logic wr_stop;
    logic rd_stop;
    logic wr_go;
    logic rd_go;
    logic rd_side;
    logic commit_ok;
    logic unused_flag;

    // Request qualification and burst limits
    assign tx_req      = TX_VALID & FLAGN[1];
    assign rx_req      = FLAGN[0] & RX_READY;
    assign burst_full  = (burst_cnt == BW'(BURST_MAX));
    assign wr_stop     = flush_pend | (burst_full & rx_req);
    assign rd_stop     = burst_full & tx_req;
    assign wr_go       = (state == S_WR) & tx_req & ~wr_stop;
    assign rd_go       = (state == S_RD) & rx_req & ~rd_stop;
    assign unused_flag = FLAGN[2];

`ifdef FX2_ZLP_EN
    assign commit_ok = 1'b1;
`else
    assign commit_ok = (pkt_cnt != '0);
`endif

    // Read side of the bus: output enable held through the turnaround after a read
    assign rd_side = (state == S_RD_SETUP) | (state == S_RD) | ((state == S_TURN) & last_rd);

    // Bus pins decoded from state; write/read strobes follow the flags with zero latency
    assign TX_READY = (state == S_WR) & FLAGN[1] & ~wr_stop;
    assign SLWRN    = ~wr_go;
    assign SLRDN    = ~rd_go;
    assign SLOEN    = ~rd_side;
    assign FIFOADR  = rd_side ? RD_EP_ADDR : WR_EP_ADDR;
    assign PKTENDN  = ~(state == S_PKTEND);
    assign FD       = (state == S_WR) ? TX_DATA : 8'hzz;

    // Arbitration FSM, counters and RX capture
    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            pkt_cnt    <= '0;
            burst_cnt  <= '0;
            flush_pend <= 1'b0;
            last_rd    <= 1'b0;
            RX_DATA    <= 8'h00;
            RX_VALID   <= 1'b0;
        end else begin
            RX_VALID <= rd_go;
            if (rd_go) begin
                RX_DATA <= FD;
            end
            if (wr_go) begin
                pkt_cnt <= (pkt_cnt == PW'(PKT_BYTES - 1)) ? '0 : pkt_cnt + PW'(1);
            end
            if ((wr_go | rd_go) & ~burst_full) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
            if (FLUSH) begin
                flush_pend <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (flush_pend & commit_ok) begin
                        state <= S_PKTEND;
                    end else begin
                        if (flush_pend) begin
                            flush_pend <= FLUSH;
                        end
                        if (tx_req & (~rx_req | last_rd)) begin
                            state   <= S_WR;
                            last_rd <= 1'b0;
                        end else if (rx_req) begin
                            state   <= S_RD_SETUP;
                            last_rd <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (~tx_req | wr_stop) begin
                        state <= S_TURN;
                    end
                end
                S_RD_SETUP: begin
                    state <= S_RD;
                end
                S_RD: begin
                    if (~rx_req | rd_stop) begin
                        state <= S_TURN;
                    end
                end
                S_TURN: begin
                    burst_cnt <= '0;
                    state     <= S_IDLE;
                end
                S_PKTEND: begin
                    pkt_cnt    <= '0;
                    flush_pend <= FLUSH;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Testbench for fx2_fifo_arbiter: FX2 bus model with write/read scoreboards,
// a table of write/flush scenarios and hand-written arbitration sequences.
module tb_fx2_fifo_arbiter;

`ifdef FX2_ZLP_EN
    localparam int ZLP = 1;
`else
    localparam int ZLP = 0;
`endif

    logic       ifclk = 1'b0;
    logic       reset;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid;
    logic       tx_ready;
    logic       flush;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    wire  [7:0] fd;
    logic       slrdn, slwrn, sloen, pktendn;
    logic [1:0] fifoadr;
    logic [2:0] flagn;

    logic [7:0] rd_val = 8'h40;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    int rx_seen  = 0;
    int pktend_lows = 0;
    int cur_dir = 0;
    int run_len = 0;
    int gap     = 0;
    int bursts_checked = 0;

    logic mon_en     = 1'b0;
    logic burst_mode = 1'b0;
    logic tx_acc     = 1'b0;
    logic rd_take    = 1'b0;
    logic rd_prev    = 1'b0;
    logic pk_prev    = 1'b0;

    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    typedef struct {
        int nbytes;
        bit do_flush;
        int exp_pulses;
    } vec_t;

    vec_t vt[8];

    // FX2 side: drives FD while the arbiter has output enable asserted
    assign fd = sloen ? 8'hzz : rd_val;

    fx2_fifo_arbiter dut (
        .IFCLK    (ifclk),
        .RESET    (reset),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .FLUSH    (flush),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready),
        .FD       (fd),
        .SLRDN    (slrdn),
        .SLWRN    (slwrn),
        .SLOEN    (sloen),
        .PKTENDN  (pktendn),
        .FIFOADR  (fifoadr),
        .FLAGN    (flagn)
    );

    always #10 ifclk = ~ifclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the sources move on only after the DUT took their value
    task automatic step();
        @(posedge ifclk);
        #1;
        if (tx_acc) tx_data = tx_data + 8'd1;
        if (rd_take) rd_val = rd_val + 8'd3;
    endtask

    // Bus monitor and scoreboards, sampled on the falling edge
    always @(negedge ifclk) begin
        if (mon_en) begin
            int d;
            tx_acc = tx_valid & tx_ready;
            chk("slwrn_vs_accept", int'(!slwrn), int'(tx_acc));
            chk("no_dual_strobe", int'(!slwrn && !slrdn), 0);
            if (tx_acc) wr_q.push_back(tx_data);
            if (!slwrn) begin
                chk("wr_with_sloen_high", int'(sloen), 1);
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_byte", int'(fd), int'(wr_q.pop_front()));
                wr_seen++;
            end
            if (!flagn[1]) begin
                chk("full_slwrn", int'(slwrn), 1);
                chk("full_tx_ready", int'(tx_ready), 0);
            end
            if (!slrdn) chk("slrdn_needs_ready", int'(rx_ready), 1);
            if (!sloen) chk("fd_not_driven", int'(fd), int'(rd_val));
            chk("rx_valid_latency", int'(rx_valid), int'(rd_prev));
            if (rx_valid) begin
                if (rd_q.size() == 0) chk("rx_unexpected", 1, 0);
                else chk("rx_byte", int'(rx_data), int'(rd_q.pop_front()));
                rx_seen++;
            end
            rd_take = !slrdn;
            if (rd_take) rd_q.push_back(rd_val);
            rd_prev = rd_take;
            if (!pktendn) begin
                pktend_lows++;
                chk("pktend_width", int'(pk_prev), 0);
                chk("pktend_fifoadr", int'(fifoadr), 2);
            end
            pk_prev = !pktendn;
            if (burst_mode) begin
                d = !slwrn ? 1 : (!slrdn ? 2 : 0);
                if (d == 0) begin
                    gap++;
                end else begin
                    if (d != cur_dir) begin
                        if (cur_dir != 0) begin
                            chk("burst_len", run_len, 64);
                            chk("turn_gap_ok", int'(gap >= 2 && gap <= 6), 1);
                            bursts_checked++;
                        end
                        cur_dir = d;
                        run_len = 0;
                    end
                    run_len++;
                    gap = 0;
                end
            end
        end
    end

    initial begin
        int base;
        int budget;
        int target;
        int w25;

        vt[0] = '{520, 1'b0, 0};
        vt[1] = '{0,   1'b1, 1};
        vt[2] = '{0,   1'b1, ZLP};
        vt[3] = '{10,  1'b1, 1};
        vt[4] = '{512, 1'b1, ZLP};
        vt[5] = '{5,   1'b0, 0};
        vt[6] = '{507, 1'b1, ZLP};
        vt[7] = '{100, 1'b1, 1};

        // Reset held with a pending write request
        reset    = 1'b1;
        tx_valid = 1'b1;
        flush    = 1'b0;
        rx_ready = 1'b0;
        flagn    = 3'b011;
        repeat (3) step();
        @(negedge ifclk);
        chk("rst_slwrn", int'(slwrn), 1);
        chk("rst_slrdn", int'(slrdn), 1);
        chk("rst_sloen", int'(sloen), 1);
        chk("rst_pktendn", int'(pktendn), 1);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_fifoadr", int'(fifoadr), 2);
        tx_valid = 1'b0;
        flagn    = 3'b010;
        step();
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Write/flush scenario table
        for (int v = 0; v < 8; v++) begin
            pktend_lows = 0;
            base   = wr_seen;
            flagn  = 3'b010;
            target = vt[v].do_flush ? vt[v].nbytes - 1 : vt[v].nbytes;
            if (vt[v].nbytes > 0) begin
                tx_valid = 1'b1;
                budget = 4 * vt[v].nbytes + 50;
                while ((wr_seen - base) < target && budget > 0) begin
                    step();
                    budget--;
                end
                if (budget == 0) chk("write_timeout", 1, 0);
            end
            if (vt[v].do_flush) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            tx_valid = 1'b0;
            repeat (8) step();
            chk("pkt_bytes_written", wr_seen - base, vt[v].nbytes);
            chk("pktend_pulses", pktend_lows, vt[v].exp_pulses);
        end

        // Both directions continuously pending: alternating full bursts
        flagn    = 3'b011;
        cur_dir  = 0;
        gap      = 0;
        run_len  = 0;
        burst_mode = 1'b1;
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        repeat (700) step();
        burst_mode = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (8) step();
        chk("bursts_seen", int'(bursts_checked >= 6), 1);
        chk("rd_queue_drained", rd_q.size(), 0);

        // Write endpoint goes full mid-burst and recovers
        flagn    = 3'b010;
        tx_valid = 1'b1;
        w25 = 0;
        for (int i = 0; i < 60; i++) begin
            flagn[1] = !((i >= 15 && i <= 24) || (i >= 35 && i <= 37));
            if (i == 25) w25 = wr_seen;
            step();
        end
        tx_valid = 1'b0;
        flagn    = 3'b010;
        repeat (6) step();
        chk("write_resumed", int'(wr_seen > w25), 1);
        chk("wr_queue_drained", wr_q.size(), 0);

        // Reads with the sink toggling ready every cycle
        base     = rx_seen;
        flagn    = 3'b001;
        for (int i = 0; i < 60; i++) begin
            rx_ready = (i % 2) == 1;
            step();
        end
        rx_ready = 1'b0;
        repeat (6) step();
        chk("reads_with_toggle", int'((rx_seen - base) > 5), 1);
        chk("rd_queue_empty", rd_q.size(), 0);

        // Reset in the middle of a write burst stops the strobes
        flagn    = 3'b010;
        tx_valid = 1'b1;
        repeat (6) step();
        reset = 1'b1;
        step();
        @(negedge ifclk);
        chk("midburst_rst_slwrn", int'(slwrn), 1);
        chk("midburst_rst_ready", int'(tx_ready), 0);
        tx_valid = 1'b0;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("midburst_wr_queue", wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
